// File: rtl/reg_file_pkg.sv
// Shared CPU definitions: register-file geometry and architectural register numbers,
// reused by the ALU and PC stages.
package reg_file_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic [15:0] WR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle: two read ports, one write-back port, debug write counter.
interface reg_file_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [DW-1:0] busA;
  logic [DW-1:0] busB;
  logic [15:0]   wr_cnt;

  modport master (
    output ra, rb, we, wa, wd,
    input  busA, busB, wr_cnt
  );

  modport slave (
    input  ra, rb, we, wa, wd,
    output busA, busB, wr_cnt
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: forces register 0 to zero and optionally forwards
// same-cycle write data.
module rf_read_port #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] stored,
  input  logic          wr_ok,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic hit;

  // wr_ok already excludes address 0 and reset, so a hit is always a real commit.
  assign hit = BYPASS && wr_ok && (waddr == raddr);

  always_comb begin
    rdata = stored;
    if (raddr == '0) rdata = '0;
    else if (hit)    rdata = wdata;
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit register file with $zero, optional write-to-read bypass and a
// saturating committed-write counter.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter bit BYPASS = 1'b1
) (
  input logic         clk,
  input logic         rst,
  reg_file_if.slave   rf
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] mem [NREG];
  logic [15:0]   wr_cnt_q;
  logic          wr_ok;

  // Reset wins over a coincident write, and a write to $zero never commits.
  assign wr_ok = rf.we && (rf.wa != '0) && !rst;

  // NOTE: the array is cleared by reset because software relies on every register
  // reading 0 after reset; this costs a reset net per bit and rules out RAM macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      wr_cnt_q <= '0;
    end else if (wr_ok) begin
      mem[rf.wa] <= rf.wd;
      if (wr_cnt_q != WR_CNT_MAX) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rf.wr_cnt = wr_cnt_q;

  rf_read_port #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_port_a (
    .raddr  (rf.ra),
    .stored (mem[rf.ra]),
    .wr_ok  (wr_ok),
    .waddr  (rf.wa),
    .wdata  (rf.wd),
    .rdata  (rf.busA)
  );

  rf_read_port #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_port_b (
    .raddr  (rf.rb),
    .stored (mem[rf.rb]),
    .wr_ok  (wr_ok),
    .waddr  (rf.wa),
    .wdata  (rf.wd),
    .rdata  (rf.busB)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one DUT with bypass, one without, driven in lockstep.
module tb_reg_file;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_if #(.DW(32), .AW(5)) if1 ();
  reg_file_if #(.DW(32), .AW(5)) if0 ();

  reg_file #(.DW(32), .AW(5), .BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .rf(if1));
  reg_file #(.DW(32), .AW(5), .BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .rf(if0));

  task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    if1.ra = ra; if1.rb = rb; if1.we = we; if1.wa = wa; if1.wd = wd;
    if0.ra = ra; if0.rb = rb; if0.we = we; if0.wa = wa; if0.wd = wd;
  endtask

  // Advance past the next rising edge, sampling 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] wa, input logic [31:0] wd);
    drive(5'd0, 5'd0, 1'b1, wa, wd);
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    // rst is high from time 0; write attempt to r6 held across an edge.
    drive(5'd5, 5'd6, 1'b1, 5'd6, 32'd55);
    @(negedge clk); #1;
    checks++;
    if (if1.busA !== 32'd0) begin errors++; $display("FAIL reset_busA got %h want %h", if1.busA, 32'd0); end
    checks++;
    if (if1.wr_cnt !== 16'd0) begin errors++; $display("FAIL reset_wr_cnt got %h want %h", if1.wr_cnt, 16'd0); end
    checks++;
    if (if1.busB !== 32'd0) begin errors++; $display("FAIL reset_no_bypass got %h want %h", if1.busB, 32'd0); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    drive(5'd5, 5'd6, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (if1.busB !== 32'd0) begin errors++; $display("FAIL reset_blocks_write got %h want %h", if1.busB, 32'd0); end
    // Preload r5, then assert reset mid-cycle.
    write_reg(5'd5, 32'h1234);
    drive(5'd5, 5'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (if1.busA !== 32'h1234) begin errors++; $display("FAIL preload_r5 got %h want %h", if1.busA, 32'h1234); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (if1.busA !== 32'd0) begin errors++; $display("FAIL async_reset_busA got %h want %h", if1.busA, 32'd0); end
    checks++;
    if (if0.wr_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_wr_cnt got %h want %h", if0.wr_cnt, 16'd0); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    write_reg(5'd3, 32'hDEADBEEF);
    drive(5'd3, 5'd3, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (if1.busA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_busA got %h want %h", if1.busA, 32'hDEADBEEF); end
    checks++;
    if (if1.busB !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_busB got %h want %h", if1.busB, 32'hDEADBEEF); end
    checks++;
    if (if0.busA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_busA_nobyp got %h want %h", if0.busA, 32'hDEADBEEF); end
    checks++;
    if (if1.wr_cnt !== 16'd1) begin errors++; $display("FAIL wr_cnt_one got %h want %h", if1.wr_cnt, 16'd1); end
  endtask

  task automatic test_zero();
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    checks++;
    if (if1.busA !== 32'd0) begin errors++; $display("FAIL zero_no_bypass got %h want %h", if1.busA, 32'd0); end
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (if1.busA !== 32'd0) begin errors++; $display("FAIL zero_read got %h want %h", if1.busA, 32'd0); end
    checks++;
    if (if1.wr_cnt !== 16'd1) begin errors++; $display("FAIL zero_wr_cnt got %h want %h", if1.wr_cnt, 16'd1); end
  endtask

  task automatic test_bypass();
    write_reg(5'd7, 32'd1);
    drive(5'd7, 5'd7, 1'b1, 5'd7, 32'd2);
    #1;
    checks++;
    if (if1.busA !== 32'd2) begin errors++; $display("FAIL byp1_busA got %h want %h", if1.busA, 32'd2); end
    checks++;
    if (if1.busB !== 32'd2) begin errors++; $display("FAIL byp1_busB got %h want %h", if1.busB, 32'd2); end
    checks++;
    if (if0.busA !== 32'd1) begin errors++; $display("FAIL byp0_busA_before got %h want %h", if0.busA, 32'd1); end
    checks++;
    if (if0.busB !== 32'd1) begin errors++; $display("FAIL byp0_busB_before got %h want %h", if0.busB, 32'd1); end
    tick();
    drive(5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (if0.busA !== 32'd2) begin errors++; $display("FAIL byp0_busA_after got %h want %h", if0.busA, 32'd2); end
    checks++;
    if (if1.wr_cnt !== 16'd3) begin errors++; $display("FAIL byp_wr_cnt got %h want %h", if1.wr_cnt, 16'd3); end
    // Only port B matches the write address.
    drive(5'd7, 5'd8, 1'b1, 5'd8, 32'hAA);
    #1;
    checks++;
    if (if1.busA !== 32'd2) begin errors++; $display("FAIL byp_indep_busA got %h want %h", if1.busA, 32'd2); end
    checks++;
    if (if1.busB !== 32'hAA) begin errors++; $display("FAIL byp_indep_busB got %h want %h", if1.busB, 32'hAA); end
    checks++;
    if (if0.busB !== 32'd0) begin errors++; $display("FAIL byp0_indep_busB got %h want %h", if0.busB, 32'd0); end
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_alu_operands();
    logic [31:0] result;
    write_reg(5'd1, 32'h7FFFFFFF);
    write_reg(5'd2, 32'd1);
    drive(5'd1, 5'd2, 1'b0, 5'd0, 32'd0);
    #1;
    result = if1.busA + if1.busB;
    checks++;
    if (result !== 32'h80000000) begin errors++; $display("FAIL alu_add got %h want %h", result, 32'h80000000); end
    checks++;
    if ((result == 32'd0) !== 1'b0) begin errors++; $display("FAIL alu_zero got %b want %b", (result == 32'd0), 1'b0); end
    checks++;
    if (if0.busB !== 32'd1) begin errors++; $display("FAIL alu_busB got %h want %h", if0.busB, 32'd1); end
    checks++;
    if (if1.wr_cnt !== 16'd6) begin errors++; $display("FAIL alu_wr_cnt got %h want %h", if1.wr_cnt, 16'd6); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      drive(5'd9, 5'd0, 1'b1, 5'd9, 32'(i));
      tick();
    end
    drive(5'd9, 5'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (if1.wr_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want %h", if1.wr_cnt, 16'hFFFF); end
    checks++;
    if (if1.busA !== 32'h0000FFFE) begin errors++; $display("FAIL sat_r9_mid got %h want %h", if1.busA, 32'h0000FFFE); end
    drive(5'd9, 5'd0, 1'b1, 5'd9, 32'h12345678);
    tick();
    drive(5'd9, 5'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (if1.wr_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want %h", if1.wr_cnt, 16'hFFFF); end
    checks++;
    if (if0.wr_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_nobyp got %h want %h", if0.wr_cnt, 16'hFFFF); end
    checks++;
    if (if1.busA !== 32'h12345678) begin errors++; $display("FAIL sat_r9_last got %h want %h", if1.busA, 32'h12345678); end
  endtask

  initial begin
    rst = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    test_reset();
    test_write_read();
    test_zero();
    test_bypass();
    test_alu_operands();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
